// File: rtl/i2c_reg_target.sv
// I2C target front-end: oversampled SCL/SDA, START/STOP detection, 7-bit address match
// and an auto-incrementing 8-bit register pointer for multi-byte writes and reads.
module i2c_reg_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       reg_re,
    output logic       busy,
    output logic       addr_match
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_ADDR,
        ST_ACK_ADDR,
        ST_RX_PTR,
        ST_ACK_PTR,
        ST_RX_DATA,
        ST_ACK_DATA,
        ST_TX_DATA,
        ST_RX_ACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rw;
    logic                r_sda_oe;
    logic [BYTE_W-1:0]   r_addr;
    logic [BYTE_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_re;
    logic                r_busy;
    logic                r_match;

    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_rw_nxt;
    logic                w_sda_oe_nxt;
    logic [BYTE_W-1:0]   w_addr_nxt;
    logic [BYTE_W-1:0]   w_wdata_nxt;
    logic                w_we_nxt;
    logic                w_re_nxt;
    logic                w_busy_nxt;
    logic                w_match_nxt;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_byte_done;

    // Pad synchronisers plus one delay stage for edge/condition detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl       = r_scl_sync[SYNC_STAGES-1];
    assign w_sda       = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise  = w_scl & ~r_scl_d;
    assign w_scl_fall  = ~w_scl & r_scl_d;
    assign w_start     = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop      = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte_done = w_scl_fall && (r_cnt == CNT_W'(8));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_rw     <= 1'b0;
            r_sda_oe <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_busy   <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rw     <= w_rw_nxt;
            r_sda_oe <= w_sda_oe_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_re     <= w_re_nxt;
            r_busy   <= w_busy_nxt;
            r_match  <= w_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_rw_nxt     = r_rw;
        w_sda_oe_nxt = r_sda_oe;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = 1'b0;
        w_re_nxt     = 1'b0;
        w_busy_nxt   = r_busy;
        w_match_nxt  = 1'b0;

        if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_cnt_nxt    = '0;
            w_shift_nxt  = '0;
        end else if (w_start) begin
            // Repeated START keeps pointer and busy; the byte in flight is dropped
            w_state_nxt  = ST_RX_ADDR;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_shift_nxt  = '0;
        end else begin
            case (r_state)
                ST_RX_ADDR, ST_RX_PTR, ST_RX_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda};
                        w_cnt_nxt   = CNT_W'(r_cnt + CNT_W'(1));
                    end else if (w_byte_done) begin
                        w_cnt_nxt    = '0;
                        w_sda_oe_nxt = 1'b1;
                        if (r_state == ST_RX_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_match_nxt = 1'b1;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = r_shift[0];
                                w_state_nxt = ST_ACK_ADDR;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = ST_IGNORE;
                            end
                        end else if (r_state == ST_RX_PTR) begin
                            w_addr_nxt  = r_shift;
                            w_state_nxt = ST_ACK_PTR;
                        end else begin
                            w_wdata_nxt = r_shift;
                            w_we_nxt    = 1'b1;
                            w_state_nxt = ST_ACK_DATA;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        if (r_rw) begin
                            w_re_nxt    = 1'b1;
                            w_state_nxt = ST_TX_DATA;
                        end else begin
                            w_state_nxt = ST_RX_PTR;
                        end
                    end
                end
                ST_ACK_PTR: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = ST_RX_DATA;
                    end
                end
                ST_ACK_DATA: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_addr_nxt   = BYTE_W'(r_addr + BYTE_W'(1));
                        w_state_nxt  = ST_RX_DATA;
                    end
                end
                ST_TX_DATA: begin
                    // reg_re cycle captures read data and drives the MSB
                    if (r_re) begin
                        w_shift_nxt  = reg_rdata;
                        w_sda_oe_nxt = ~reg_rdata[7];
                    end else if (w_scl_rise) begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end else if (w_byte_done) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_RX_ACK;
                    end else if (w_scl_fall) begin
                        w_shift_nxt  = {r_shift[BYTE_W-2:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
                ST_RX_ACK: begin
                    // r_cnt flags a received ACK between its rising and falling edges
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_addr_nxt = BYTE_W'(r_addr + BYTE_W'(1));
                            w_cnt_nxt  = CNT_W'(1);
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                            w_state_nxt  = ST_IGNORE;
                        end
                    end else if (w_scl_fall && (r_cnt == CNT_W'(1))) begin
                        w_re_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_TX_DATA;
                    end
                end
                ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                ST_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe     = r_sda_oe;
    assign reg_addr   = r_addr;
    assign reg_wdata  = r_wdata;
    assign reg_we     = r_we;
    assign reg_re     = r_re;
    assign busy       = r_busy;
    assign addr_match = r_match;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C controller, a register bank on the
// register port, and a transaction-level model of pointer and memory contents.
module tb_i2c_reg_target;

    localparam logic [6:0] DEV = 7'h50;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv;
    logic       sda_drv;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       reg_re;
    logic       busy;
    logic       addr_match;

    logic [7:0]  bank [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] we_log [$];
    logic [7:0]  re_log [$];
    logic [7:0]  tx_bytes [$];
    int          match_cnt = 0;
    int          oe_cycles = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low
    assign sda_i     = sda_drv & ~sda_oe;
    assign reg_rdata = bank[reg_addr];

    i2c_reg_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_drv),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_rdata  (reg_rdata),
        .reg_re     (reg_re),
        .busy       (busy),
        .addr_match (addr_match)
    );

    always @(negedge clk) begin
        if (reg_we) begin
            we_log.push_back({reg_addr, reg_wdata});
            bank[reg_addr] <= reg_wdata;
        end
        if (reg_re) re_log.push_back(reg_addr);
        if (addr_match) match_cnt <= match_cnt + 1;
        if (sda_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        if (!scl_drv) begin
            sda_drv = 1'b1; tick(Q);
            scl_drv = 1'b1; tick(Q);
        end
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_drv = b;    tick(Q);
        scl_drv = 1'b1; tick(Q);
        s = sda_i;      tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~ack, s);
    endtask

    // Write transaction: address, pointer, then tx_bytes; model tracks memory and pointer
    task automatic txn_write(input logic [6:0] dev, input logic [7:0] ptr, input string tag);
        logic        ack;
        logic        hit;
        logic [15:0] exp_we [$];
        hit = (dev == DEV);
        we_log.delete();
        bus_start();
        send_byte({dev, 1'b0}, ack);
        check({tag, "_addr_ack"}, 16'(ack), 16'(hit));
        if (hit) begin
            check({tag, "_busy"}, 16'(busy), 16'd1);
            send_byte(ptr, ack);
            check({tag, "_ptr_ack"}, 16'(ack), 16'd1);
            model_ptr = ptr;
            foreach (tx_bytes[i]) begin
                send_byte(tx_bytes[i], ack);
                check({tag, "_data_ack"}, 16'(ack), 16'd1);
                exp_we.push_back({model_ptr, tx_bytes[i]});
                model_mem[model_ptr] = tx_bytes[i];
                model_ptr = model_ptr + 8'd1;
            end
        end else begin
            send_byte(ptr, ack);
            check({tag, "_ptr_nack"}, 16'(ack), 16'd0);
        end
        bus_stop();
        check({tag, "_we_count"}, 16'(we_log.size()), 16'(exp_we.size()));
        for (int i = 0; i < exp_we.size() && i < we_log.size(); i++)
            check({tag, "_we_entry"}, we_log[i], exp_we[i]);
        check({tag, "_ptr_final"}, 16'(reg_addr), 16'(model_ptr));
        check({tag, "_busy_after"}, 16'(busy), 16'd0);
    endtask

    // Read transaction: optional pointer set + repeated START, n bytes, last one NACKed
    task automatic txn_read(input logic set_ptr, input logic [7:0] ptr, input int n,
                            input string tag);
        logic       ack;
        logic [7:0] d;
        logic [7:0] exp_re [$];
        re_log.delete();
        bus_start();
        if (set_ptr) begin
            send_byte({DEV, 1'b0}, ack);
            check({tag, "_waddr_ack"}, 16'(ack), 16'd1);
            send_byte(ptr, ack);
            check({tag, "_ptr_ack"}, 16'(ack), 16'd1);
            model_ptr = ptr;
            bus_start();
        end
        send_byte({DEV, 1'b1}, ack);
        check({tag, "_raddr_ack"}, 16'(ack), 16'd1);
        check({tag, "_busy"}, 16'(busy), 16'd1);
        for (int i = 0; i < n; i++) begin
            exp_re.push_back(model_ptr);
            recv_byte(i != n - 1, d);
            check({tag, "_rdata"}, 16'(d), 16'(model_mem[model_ptr]));
            if (i != n - 1) model_ptr = model_ptr + 8'd1;
        end
        check({tag, "_oe_nack"}, 16'(sda_oe), 16'd0);
        check({tag, "_busy_nack"}, 16'(busy), 16'd0);
        bus_stop();
        check({tag, "_re_count"}, 16'(re_log.size()), 16'(exp_re.size()));
        for (int i = 0; i < exp_re.size() && i < re_log.size(); i++)
            check({tag, "_re_addr"}, 16'(re_log[i]), 16'(exp_re[i]));
        check({tag, "_ptr_final"}, 16'(reg_addr), 16'(model_ptr));
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         base_match;
        int         base_oe;
        logic [6:0] dev;
        int         kind;
        int         n;

        for (int i = 0; i < 256; i++) begin
            bank[i]      = 8'(8'h80 + i);
            model_mem[i] = 8'(8'h80 + i);
        end
        model_ptr = 8'h00;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        rst = 1'b0;
        tick(4);
        check("rst_sda_oe", 16'(sda_oe), 16'd0);
        check("rst_reg_addr", 16'(reg_addr), 16'd0);
        check("rst_reg_wdata", 16'(reg_wdata), 16'd0);
        check("rst_strobes", 16'({reg_we, reg_re, addr_match}), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        rst = 1'b1;
        tick(4);

        tx_bytes = '{8'h5A, 8'hC3};
        txn_write(DEV, 8'h10, "wr");

        txn_read(1'b1, 8'h20, 2, "rd");

        base_match = match_cnt;
        base_oe = oe_cycles;
        tx_bytes = '{};
        txn_write(7'h51, 8'h11, "mis");
        check("mis_oe_never", 16'(oe_cycles - base_oe), 16'd0);
        check("mis_no_match", 16'(match_cnt - base_match), 16'd0);

        tx_bytes = '{8'h01, 8'h02};
        txn_write(DEV, 8'hFF, "wrap");

        // STOP in the middle of a data byte
        we_log.delete();
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("pstop_addr_ack", 16'(ack), 16'd1);
        send_byte(8'h30, ack);
        check("pstop_ptr_ack", 16'(ack), 16'd1);
        model_ptr = 8'h30;
        for (int i = 0; i < 4; i++) bus_bit(1'(i & 1), s);
        bus_stop();
        check("pstop_no_we", 16'(we_log.size()), 16'd0);
        check("pstop_oe", 16'(sda_oe), 16'd0);
        check("pstop_busy", 16'(busy), 16'd0);
        check("pstop_ptr", 16'(reg_addr), 16'h30);

        // Reset while the target is pulling SDA low for the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'hA0 >> i) & 8'h01) != 0, s);
        check("rstack_driving", 16'(sda_oe), 16'd1);
        rst = 1'b0;
        tick(1);
        check("rstack_oe", 16'(sda_oe), 16'd0);
        check("rstack_addr", 16'(reg_addr), 16'd0);
        check("rstack_wdata", 16'(reg_wdata), 16'd0);
        check("rstack_strobes", 16'({reg_we, reg_re, addr_match}), 16'd0);
        check("rstack_busy", 16'(busy), 16'd0);
        rst = 1'b1;
        model_ptr = 8'h00;
        bus_stop();
        tx_bytes = '{8'h99, 8'h3C};
        txn_write(DEV, 8'h42, "post_rst");

        // Randomized transactions against the model
        for (int i = 0; i < 256; i++) begin
            bank[i]      = 8'($urandom);
            model_mem[i] = bank[i];
        end
        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 4));
            if (kind == 0 || kind == 3) begin
                dev = DEV;
                if (kind == 3) begin
                    dev = 7'($urandom_range(0, 127));
                    if (dev == DEV) dev = 7'h2A;
                end
                tx_bytes = '{};
                for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
                txn_write(dev, 8'($urandom), "rnd_wr");
            end else begin
                txn_read(kind == 1, 8'($urandom), n, "rnd_rd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
